// File: rtl/ir_prefetch_queue.sv
// ---------------------------------------------------------------------------
// ir_prefetch_queue
//   Instruction register with a small prefetch FIFO for the 8-bit CPU core.
//   Fetched bus words are buffered in a circular FIFO. The word at the head is
//   decoded as a one-word (short) or two-word (long) instruction. Once all of
//   its words are buffered, it moves into the instruction register. This
//   happens when the IR is empty or when the controller retires the current
//   instruction.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   fetch_valid  fetch_data holds a valid instruction word
//   fetch_data   fetched instruction word (BUS_W)
//   fetch_ready  FIFO can accept a word (count < DEPTH)
//   flush        discard FIFO contents and the current instruction
//   ir_next      controller retires the current instruction
//   ir_valid     ir_op / ir_operand hold a valid instruction
//   ir_op        current opcode (OP_W)
//   ir_operand   current operand (OPR_W)
//   ir_long      current instruction is two-word
//   ir_out       operand bus output enable
//   opr_bus      ir_out ? ir_operand : 0
//   fifo_count   number of words buffered in the FIFO
// ---------------------------------------------------------------------------
module ir_prefetch_queue #(
    parameter int              BUS_W        = 8,
    parameter int              OP_W         = 4,
    parameter int              DEPTH        = 4,
    parameter logic [OP_W-1:0] LONG_OP_BASE = 4'hC,
    localparam int             OPR_W        = 2*BUS_W-OP_W,
    localparam int             CNT_W        = $clog2(DEPTH+1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fetch_valid,
    input  logic [BUS_W-1:0] fetch_data,
    output logic             fetch_ready,
    input  logic             flush,
    input  logic             ir_next,
    output logic             ir_valid,
    output logic [OP_W-1:0]  ir_op,
    output logic [OPR_W-1:0] ir_operand,
    output logic             ir_long,
    input  logic             ir_out,
    output logic [OPR_W-1:0] opr_bus,
    output logic [CNT_W-1:0] fifo_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LOW_W = BUS_W - OP_W;

    // Advance a pointer by 0..2 with wrap modulo DEPTH (DEPTH need not be a
    // power of two, so a plain overflow wrap is not enough).
    function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p,
                                                  input logic [1:0]       n);
        logic [PTR_W:0] s;
        s = (PTR_W+1)'(p) + (PTR_W+1)'(n);
        if (s >= (PTR_W+1)'(DEPTH))
            s = s - (PTR_W+1)'(DEPTH);
        return s[PTR_W-1:0];
    endfunction

    logic [BUS_W-1:0] mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0] count_reg,  count_next;

    logic             ir_valid_reg,   ir_valid_next;
    logic [OP_W-1:0]  ir_op_reg,      ir_op_next;
    logic [OPR_W-1:0] ir_operand_reg, ir_operand_next;
    logic             ir_long_reg,    ir_long_next;

    logic [BUS_W-1:0] head_word;
    logic [BUS_W-1:0] head2_word;
    logic [OP_W-1:0]  head_op;
    logic [LOW_W-1:0] head_low;
    logic             head_long;
    logic             complete;
    logic             push;
    logic             load;
    logic [1:0]       pop_n;

    // Head decode. The second word of a long instruction may sit at index 0
    // after the head at DEPTH-1, so its index is wrapped.
    always_comb begin
        head_word  = mem[rd_ptr_reg];
        head2_word = mem[ptr_add(rd_ptr_reg, 2'd1)];
        head_op    = head_word[BUS_W-1 -: OP_W];
        head_low   = head_word[LOW_W-1:0];
        head_long  = (head_op >= LONG_OP_BASE);
        // Only registered count is used: a word pushed this cycle cannot
        // complete an instruction in the same cycle.
        complete   = head_long ? (count_reg >= CNT_W'(2)) : (count_reg >= CNT_W'(1));
    end

    assign fetch_ready = (count_reg < CNT_W'(DEPTH));
    assign push        = fetch_valid && fetch_ready && !flush;
    assign load        = complete && (!ir_valid_reg || ir_next) && !flush;

    always_comb begin
        pop_n           = 2'd0;
        wr_ptr_next     = wr_ptr_reg;
        rd_ptr_next     = rd_ptr_reg;
        count_next      = count_reg;
        ir_valid_next   = ir_valid_reg;
        ir_op_next      = ir_op_reg;
        ir_operand_next = ir_operand_reg;
        ir_long_next    = ir_long_reg;

        if (flush) begin
            // Pointers restart at 0 so no stale word can reappear at the head.
            wr_ptr_next   = '0;
            rd_ptr_next   = '0;
            count_next    = '0;
            ir_valid_next = 1'b0;
        end else begin
            if (load) begin
                pop_n         = head_long ? 2'd2 : 2'd1;
                ir_valid_next = 1'b1;
                ir_op_next    = head_op;
                ir_long_next  = head_long;
                if (head_long)
                    ir_operand_next = {head_low, head2_word};
                else
                    ir_operand_next = OPR_W'(head_low);
            end else if (ir_next) begin
                // Retired with nothing complete behind it: IR goes empty but
                // keeps its last fields.
                ir_valid_next = 1'b0;
            end
            if (push)
                wr_ptr_next = ptr_add(wr_ptr_reg, 2'd1);
            rd_ptr_next = ptr_add(rd_ptr_reg, pop_n);
            count_next  = count_reg + CNT_W'(push) - CNT_W'(pop_n);
        end
    end

    // FIFO storage carries no reset; count and pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr_reg] <= fetch_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            ir_valid_reg   <= 1'b0;
            ir_op_reg      <= '0;
            ir_operand_reg <= '0;
            ir_long_reg    <= 1'b0;
        end else begin
            wr_ptr_reg     <= wr_ptr_next;
            rd_ptr_reg     <= rd_ptr_next;
            count_reg      <= count_next;
            ir_valid_reg   <= ir_valid_next;
            ir_op_reg      <= ir_op_next;
            ir_operand_reg <= ir_operand_next;
            ir_long_reg    <= ir_long_next;
        end
    end

    assign ir_valid   = ir_valid_reg;
    assign ir_op      = ir_op_reg;
    assign ir_operand = ir_operand_reg;
    assign ir_long    = ir_long_reg;
    assign fifo_count = count_reg;
    assign opr_bus    = ir_out ? ir_operand_reg : '0;

endmodule

// File: tb/tb_ir_prefetch_queue.sv
module tb_ir_prefetch_queue;

    logic        clk;
    logic        rst_n;
    logic        fetch_valid;
    logic [7:0]  fetch_data;
    logic        fetch_ready;
    logic        flush;
    logic        ir_next;
    logic        ir_valid;
    logic [3:0]  ir_op;
    logic [11:0] ir_operand;
    logic        ir_long;
    logic        ir_out;
    logic [11:0] opr_bus;
    logic [2:0]  fifo_count;

    int errors = 0;
    int checks = 0;

    ir_prefetch_queue dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fetch_valid (fetch_valid),
        .fetch_data  (fetch_data),
        .fetch_ready (fetch_ready),
        .flush       (flush),
        .ir_next     (ir_next),
        .ir_valid    (ir_valid),
        .ir_op       (ir_op),
        .ir_operand  (ir_operand),
        .ir_long     (ir_long),
        .ir_out      (ir_out),
        .opr_bus     (opr_bus),
        .fifo_count  (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; drive and sample 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        $display("reset: rst_n=0");
        #3;
        checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", ir_valid); end
        checks++; if (ir_op !== 4'h0) begin errors++; $display("FAIL rst_op: got %h want 0", ir_op); end
        checks++; if (ir_operand !== 12'h000) begin errors++; $display("FAIL rst_operand: got %h want 000", ir_operand); end
        checks++; if (ir_long !== 1'b0) begin errors++; $display("FAIL rst_long: got %b want 0", ir_long); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL rst_count: got %0d want 0", fifo_count); end
        checks++; if (fetch_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", fetch_ready); end
        #9 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_short();
        $display("short: push 0x35");
        fetch_valid = 1'b1; fetch_data = 8'h35;
        tick();
        fetch_valid = 1'b0;
        checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL short_cnt_push: got %0d want 1", fifo_count); end
        checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL short_early: got %b want 0", ir_valid); end
        tick();
        checks++; if (ir_valid !== 1'b1) begin errors++; $display("FAIL short_valid: got %b want 1", ir_valid); end
        checks++; if (ir_op !== 4'h3) begin errors++; $display("FAIL short_op: got %h want 3", ir_op); end
        checks++; if (ir_operand !== 12'h005) begin errors++; $display("FAIL short_operand: got %h want 005", ir_operand); end
        checks++; if (ir_long !== 1'b0) begin errors++; $display("FAIL short_long: got %b want 0", ir_long); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL short_cnt: got %0d want 0", fifo_count); end
        ir_next = 1'b1;
        tick();
        ir_next = 1'b0;
        checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL short_retire: got %b want 0", ir_valid); end
        checks++; if (ir_op !== 4'h3) begin errors++; $display("FAIL short_retain_op: got %h want 3", ir_op); end
    endtask

    task automatic test_long();
        $display("long: push 0xC2 then 0x7F");
        fetch_valid = 1'b1; fetch_data = 8'hC2;
        tick();
        fetch_valid = 1'b0;
        tick();
        checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL long_partial: got %b want 0", ir_valid); end
        checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL long_partial_cnt: got %0d want 1", fifo_count); end
        fetch_valid = 1'b1; fetch_data = 8'h7F;
        tick();
        fetch_valid = 1'b0;
        checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL long_same_cycle: got %b want 0", ir_valid); end
        tick();
        checks++; if (ir_valid !== 1'b1) begin errors++; $display("FAIL long_valid: got %b want 1", ir_valid); end
        checks++; if (ir_op !== 4'hC) begin errors++; $display("FAIL long_op: got %h want C", ir_op); end
        checks++; if (ir_operand !== 12'h27F) begin errors++; $display("FAIL long_operand: got %h want 27F", ir_operand); end
        checks++; if (ir_long !== 1'b1) begin errors++; $display("FAIL long_flag: got %b want 1", ir_long); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL long_cnt: got %0d want 0", fifo_count); end
        ir_next = 1'b1;
        tick();
        ir_next = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [7:0] words [6];
        words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33;
        words[3] = 8'h44; words[4] = 8'h55; words[5] = 8'h66;
        $display("back_to_back: push 0x11..0x66");
        for (int i = 0; i < 6; i++) begin
            fetch_valid = 1'b1; fetch_data = words[i];
            tick();
        end
        // 0x66 is still offered but the FIFO is full.
        checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL b2b_full_cnt: got %0d want 4", fifo_count); end
        checks++; if (fetch_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready: got %b want 0", fetch_ready); end
        checks++; if (ir_op !== 4'h1 || ir_operand !== 12'h001) begin errors++; $display("FAIL b2b_first: got op=%h opr=%h want op=1 opr=001", ir_op, ir_operand); end
        ir_next = 1'b1;
        tick();
        ir_next = 1'b0;
        checks++; if (fifo_count !== 3'd3) begin errors++; $display("FAIL b2b_pop_cnt: got %0d want 3", fifo_count); end
        checks++; if (ir_op !== 4'h2) begin errors++; $display("FAIL b2b_second: got %h want 2", ir_op); end
        tick();
        fetch_valid = 1'b0;
        checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL b2b_sixth_cnt: got %0d want 4", fifo_count); end
        ir_next = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        checks++; if (ir_op !== 4'h6 || ir_operand !== 12'h006 || ir_valid !== 1'b1) begin errors++; $display("FAIL b2b_last: got op=%h opr=%h v=%b want op=6 opr=006 v=1", ir_op, ir_operand, ir_valid); end
        tick();
        ir_next = 1'b0;
        checks++; if (ir_valid !== 1'b0 || fifo_count !== 3'd0) begin errors++; $display("FAIL b2b_drain: got v=%b cnt=%0d want v=0 cnt=0", ir_valid, fifo_count); end
    endtask

    task automatic test_flush();
        $display("flush: push 0xC2 then flush with push 0x99");
        fetch_valid = 1'b1; fetch_data = 8'hC2;
        tick();
        fetch_data = 8'h99; flush = 1'b1;
        tick();
        flush = 1'b0; fetch_valid = 1'b0;
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL flush_cnt: got %0d want 0", fifo_count); end
        checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b want 0", ir_valid); end
        fetch_valid = 1'b1; fetch_data = 8'h35;
        tick();
        fetch_valid = 1'b0;
        tick();
        checks++; if (ir_valid !== 1'b1 || ir_op !== 4'h3 || ir_long !== 1'b0) begin errors++; $display("FAIL flush_after: got v=%b op=%h long=%b want v=1 op=3 long=0", ir_valid, ir_op, ir_long); end
        ir_next = 1'b1;
        tick();
        ir_next = 1'b0;
    endtask

    task automatic test_wrap();
        // Pointers now sit at 1: 0x11->1, 0x22->2, 0xC5->3, 0xA7->0.
        $display("wrap: long 0xC5/0xA7 across FIFO end");
        fetch_valid = 1'b1; fetch_data = 8'h11; tick();
        fetch_data = 8'h22; tick();
        fetch_data = 8'hC5; tick();
        fetch_data = 8'hA7; tick();
        fetch_valid = 1'b0;
        checks++; if (fifo_count !== 3'd3 || ir_op !== 4'h1) begin errors++; $display("FAIL wrap_fill: got cnt=%0d op=%h want cnt=3 op=1", fifo_count, ir_op); end
        ir_next = 1'b1;
        tick();
        checks++; if (ir_op !== 4'h2) begin errors++; $display("FAIL wrap_mid: got %h want 2", ir_op); end
        tick();
        ir_next = 1'b0;
        checks++; if (ir_op !== 4'hC || ir_operand !== 12'h5A7 || ir_long !== 1'b1) begin errors++; $display("FAIL wrap_long: got op=%h opr=%h long=%b want op=C opr=5A7 long=1", ir_op, ir_operand, ir_long); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL wrap_cnt: got %0d want 0", fifo_count); end
        ir_out = 1'b1; #1;
        checks++; if (opr_bus !== 12'h5A7) begin errors++; $display("FAIL bus_on: got %h want 5A7", opr_bus); end
        ir_out = 1'b0; #1;
        checks++; if (opr_bus !== 12'h000) begin errors++; $display("FAIL bus_off: got %h want 000", opr_bus); end
        ir_out = 1'b1;
    endtask

    task automatic test_async_reset();
        $display("async_reset: reset between long words");
        fetch_valid = 1'b1; fetch_data = 8'hC2;
        tick();
        fetch_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (ir_valid !== 1'b0 || ir_op !== 4'h0 || ir_operand !== 12'h000 || ir_long !== 1'b0) begin errors++; $display("FAIL arst_ir: got v=%b op=%h opr=%h long=%b want all 0", ir_valid, ir_op, ir_operand, ir_long); end
        checks++; if (fifo_count !== 3'd0 || opr_bus !== 12'h000) begin errors++; $display("FAIL arst_fifo: got cnt=%0d bus=%h want 0 000", fifo_count, opr_bus); end
        #2 rst_n = 1'b1;
        tick();
        fetch_valid = 1'b1; fetch_data = 8'h35;
        tick();
        fetch_valid = 1'b0;
        tick();
        checks++; if (ir_valid !== 1'b1 || ir_op !== 4'h3 || ir_operand !== 12'h005 || ir_long !== 1'b0) begin errors++; $display("FAIL arst_after: got v=%b op=%h opr=%h long=%b want 1 3 005 0", ir_valid, ir_op, ir_operand, ir_long); end
        ir_out = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; fetch_valid = 1'b0; fetch_data = 8'h00;
        flush = 1'b0; ir_next = 1'b0; ir_out = 1'b0;
        test_reset();
        test_short();
        test_long();
        test_back_to_back();
        test_flush();
        test_wrap();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

endmodule
